amstrad_crtc: RTL and testbench
===============================

Name: amstrad_crtc

Overview:
- UM6845R (type 1) compatible CRTC timing generator.
- Runs at 1 MHz character rate and produces horizontal sync, vertical sync, display enable and the video memory address (MA/RA) for the downstream gate array pixel stage.
- Exposes the CPU register interface at ports &BCxx (select), &BDxx (write) and &BFxx (read).

Parameters:
- HS_DEFAULT, 0, selects which HSYNC width rule applies to R3[3:0]=0. 0 means no HSYNC is generated (type 1 rule); 1 means a width of 16.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- CE  in  1  character clock enable, one CLK wide, 1 MHz
- CS  in  1  chip select, qualifies WE/RD
- RS  in  1  0 = address/status, 1 = data register
- WE  in  1  write strobe, one CLK wide
- RD  in  1  read strobe
- DI  in  8  CPU write data
- DO  out  8  CPU read data, combinational from the current state
- HSYNC  out  1  horizontal sync, feeds the gate array crtc_hs
- VSYNC  out  1  vertical sync, feeds the gate array crtc_vs
- DE  out  1  display enable, feeds the gate array crtc_de
- MA  out  14  memory address
- RA  out  5  raster address (row within character)

Behaviour:
- Reset (async): all registers R0..R15 = 0, address latch = 0, all counters = 0.
- Outputs under reset: HSYNC = 0, VSYNC = 0, DE = 0, MA = 0, RA = 0.
- Register write:
  - WE & CS & ~RS: addr <= DI[4:0].
  - WE & CS & RS & addr<16: R[addr] <= DI & mask.
  - Masks: R0–R3 = FF, R4 = 7F, R5 = 1F, R6 = 7F, R7 = 7F, R8 = 03, R9 = 1F, R10 = 7F, R11 = 1F, R12 = 3F, R13 = FF, R14 = 3F, R15 = FF.
  - addr ≥ 16: write is ignored.
- Read:
  - RS=0: DO = {2'b00, vborder, 5'b0}, where vborder = (vcc ≥ R6).
  - RS=1: addr 14/15 return the register; all other addresses return 00.
- Write/count collision: the counter logic uses register values as they were before the CLK edge. A written value takes effect from the next CE.
- Counters (advance only on CE): hcc[7:0], rc[4:0], vcc[6:0], adj[4:0], hsw[3:0], vsw[3:0], state in_adjust.
- Horizontal:
  - If hcc == R0: hcc <= 0 and a line end occurs.
  - Otherwise hcc <= hcc+1.
- Line end, normal state:
  - rc == R9: rc <= 0 and a row end occurs. Otherwise rc <= rc+1.
  - Row end with vcc == R4: if R5 == 0, frame end; else in_adjust <= 1, adj <= 0.
  - Row end otherwise: vcc <= vcc+1.
- Line end, in_adjust: adj <= adj+1 and rc <= rc+1. When adj+1 == R5: frame end.
- Frame end: vcc <= 0, rc <= 0, in_adjust <= 0, row_start <= {R12,R13}.
- HSYNC:
  - Set on CE when hcc == R2 and the width is nonzero; hsw <= 0.
  - Cleared when hsw reaches width−1 on CE.
  - Width = R3[3:0]. A width of 0 follows HS_DEFAULT.
  - An R2 match while HSYNC is already active does not restart the width count.
- VSYNC:
  - Set at the start of a row (hcc == 0 and rc == 0) when vcc == R7 and not in_adjust; vsw <= 0.
  - vsw increments at each line end. VSYNC clears after exactly 16 lines (type 1 ignores R3[7:4]).
  - vcc leaving R7 does not end VSYNC early.
- DE = (hcc < R1) & (vcc < R6) & ~in_adjust. R1 = 0 or R6 = 0 forces DE = 0.
- MA:
  - MA = row_start + hcc, computed modulo 2^14.
  - At hcc == R1 with rc == R9 (normal state): next_row <= MA, and row_start <= next_row at the row end.
- RA = rc.
- All outputs are registered, 1 CLK after the CE that causes them.
- Wrap-around: hcc, rc and vcc compare by equality only. If a register is written below the current count, the counter wraps through 255/31/127 naturally and then matches.

Test Plan:
- Set R0=63, R1=40, R2=46, R3=0x8E, R4=38, R5=0, R6=25, R7=30, R9=7, R12=0x30, R13=0 -> frame length = 19968 CEs (312 lines), VSYNC period = 19968 CEs, HSYNC high for 14 CEs starting at hcc=46.
- Same setup -> DE high for 40 CEs per line on 200 lines. MA at the start of row 1 = 0x3028; RA cycles 0..7.
- VSYNC starts at line 240 of the frame and stays high for exactly 16 lines (1024 CEs). Writing R3=0x2E does not change the width.
- R5=2 with R4=38 -> frame length = 314 lines, DE = 0 during the adjust lines, RA = 8,9 on the adjust lines.
- R3=0x80 -> no HSYNC pulse at all. With HS_DEFAULT=1 -> a 16-CE pulse.
- Assert RESET mid-line -> all outputs 0 immediately. After release, hcc restarts from 0. Status read with vcc ≥ R6 returns 0x20. Read of R12 returns 00 and read of R14 returns the written value.

Source files
------------

// File: rtl/amstrad_crtc.sv
// UM6845R (type 1) compatible CRTC for the Amstrad CPC.
// Counters advance on the 1 MHz character enable. HSYNC, VSYNC, DE, MA and RA are
// registered on that enable from the next-state values, so they change one CLK after it.
module amstrad_crtc #(
  parameter bit HS_DEFAULT = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic        CS,
  input  logic        RS,
  input  logic        WE,
  input  logic        RD,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DE,
  output logic [13:0] MA,
  output logic [4:0]  RA
);

  logic [7:0] regs [16];
  logic [4:0] addr_q;

  // Writable bits of each register
  function automatic logic [7:0] reg_mask(input logic [3:0] a);
    case (a)
      4'd4, 4'd6, 4'd7, 4'd10: reg_mask = 8'h7f;
      4'd5, 4'd9, 4'd11:       reg_mask = 8'h1f;
      4'd8:                    reg_mask = 8'h03;
      4'd12, 4'd14:            reg_mask = 8'h3f;
      default:                 reg_mask = 8'hff;
    endcase
  endfunction

  logic [7:0] r0, r1, r2, r13;
  logic [3:0] r3;
  logic [6:0] r4, r6, r7;
  logic [4:0] r5, r9;
  logic [5:0] r12;

  assign r0  = regs[0];
  assign r1  = regs[1];
  assign r2  = regs[2];
  assign r3  = regs[3][3:0];
  assign r4  = regs[4][6:0];
  assign r5  = regs[5][4:0];
  assign r6  = regs[6][6:0];
  assign r7  = regs[7][6:0];
  assign r9  = regs[9][4:0];
  assign r12 = regs[12][5:0];
  assign r13 = regs[13];

  logic [7:0]  hcc_q, hcc_d;
  logic [4:0]  rc_q, rc_d, adj_q, adj_d;
  logic [6:0]  vcc_q, vcc_d;
  logic [3:0]  hsw_q, hsw_d, vsw_q, vsw_d;
  logic        in_adj_q, in_adj_d, hs_q, hs_d, vs_q, vs_d;
  logic [13:0] row_start_q, row_start_d, next_row_q;
  logic        de_q;
  logic [13:0] ma_q;
  logic        line_end, frame_end;
  logic [4:0]  hs_width;

  // CPU register interface: address latch and masked data writes
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      addr_q <= '0;
    end else if (WE && CS) begin
      if (!RS) addr_q <= DI[4:0];
      else if (!addr_q[4]) regs[addr_q[3:0]] <= DI & reg_mask(addr_q[3:0]);
    end
  end

  // Read mux: status bit 5 flags the vertical border
  always_comb begin
    DO = 8'h00;
    if (CS && RD) begin
      if (!RS) DO = {2'b00, (vcc_q >= r6), 5'b0};
      else if (addr_q == 5'd14 || addr_q == 5'd15) DO = regs[addr_q[3:0]];
    end
  end

  assign hs_width = (r3 != 4'd0) ? {1'b0, r3} : (HS_DEFAULT ? 5'd16 : 5'd0);

  // Next-state for the horizontal/vertical counters and the sync generators
  always_comb begin
    hcc_d       = hcc_q;
    rc_d        = rc_q;
    vcc_d       = vcc_q;
    adj_d       = adj_q;
    in_adj_d    = in_adj_q;
    row_start_d = row_start_q;
    hs_d        = hs_q;
    hsw_d       = hsw_q;
    vs_d        = vs_q;
    vsw_d       = vsw_q;
    frame_end   = 1'b0;
    line_end    = (hcc_q == r0);

    if (line_end) begin
      hcc_d = 8'd0;
      if (in_adj_q) begin
        adj_d = adj_q + 5'd1;
        rc_d  = rc_q + 5'd1;
        if (adj_q + 5'd1 == r5) frame_end = 1'b1;
      end else if (rc_q == r9) begin
        row_start_d = next_row_q;
        if (vcc_q == r4) begin
          if (r5 == 5'd0) begin
            frame_end = 1'b1;
          end else begin
            // Adjust lines keep counting the raster past R9
            in_adj_d = 1'b1;
            adj_d    = 5'd0;
            rc_d     = rc_q + 5'd1;
          end
        end else begin
          vcc_d = vcc_q + 7'd1;
          rc_d  = 5'd0;
        end
      end else begin
        rc_d = rc_q + 5'd1;
      end
    end else begin
      hcc_d = hcc_q + 8'd1;
    end

    if (frame_end) begin
      vcc_d       = 7'd0;
      rc_d        = 5'd0;
      in_adj_d    = 1'b0;
      row_start_d = {r12, r13};
    end

    // A match while active does not restart the width count
    if (hs_q) begin
      if (hs_width == 5'd0 || {1'b0, hsw_q} == hs_width - 5'd1) hs_d = 1'b0;
      else hsw_d = hsw_q + 4'd1;
    end else if (hcc_d == r2 && hs_width != 5'd0) begin
      hs_d  = 1'b1;
      hsw_d = 4'd0;
    end

    // Type 1: fixed 16-line vertical sync
    if (vs_q) begin
      if (line_end) begin
        if (vsw_q == 4'd15) vs_d = 1'b0;
        else vsw_d = vsw_q + 4'd1;
      end
    end else if (hcc_d == 8'd0 && rc_d == 5'd0 && vcc_d == r7 && !in_adj_d) begin
      vs_d  = 1'b1;
      vsw_d = 4'd0;
    end
  end

  // Counter, sync and output registers, advanced on the character enable
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hcc_q       <= '0;
      rc_q        <= '0;
      vcc_q       <= '0;
      adj_q       <= '0;
      in_adj_q    <= 1'b0;
      hsw_q       <= '0;
      vsw_q       <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      row_start_q <= '0;
      next_row_q  <= '0;
      de_q        <= 1'b0;
      ma_q        <= '0;
    end else if (CE) begin
      hcc_q       <= hcc_d;
      rc_q        <= rc_d;
      vcc_q       <= vcc_d;
      adj_q       <= adj_d;
      in_adj_q    <= in_adj_d;
      hsw_q       <= hsw_d;
      vsw_q       <= vsw_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      row_start_q <= row_start_d;
      // Start address of the following character row
      if (hcc_q == r1 && rc_q == r9 && !in_adj_q) next_row_q <= row_start_q + {6'd0, hcc_q};
      de_q        <= (hcc_d < r1) && (vcc_d < r6) && !in_adj_d;
      ma_q        <= row_start_d + {6'd0, hcc_d};
    end
  end

  assign HSYNC = hs_q;
  assign VSYNC = vs_q;
  assign DE    = de_q;
  assign MA    = ma_q;
  assign RA    = rc_q;

endmodule

// File: tb/tb_amstrad_crtc.sv
// Bench for amstrad_crtc: a frame-position model predicts the outputs every cycle,
// with literal expectations pinning frame length, sync placement and addresses.
module tb_amstrad_crtc;

  logic        CLK = 1'b0;
  logic        RESET, CE, CS, RS, WE, RD;
  logic [7:0]  DI;
  logic [7:0]  do0, do1;
  logic        hs0, hs1, vs0, vs1, de0, de1;
  logic [13:0] ma0, ma1;
  logic [4:0]  ra0, ra1;

  amstrad_crtc #(.HS_DEFAULT(1'b0)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .CS(CS), .RS(RS), .WE(WE), .RD(RD), .DI(DI),
    .DO(do0), .HSYNC(hs0), .VSYNC(vs0), .DE(de0), .MA(ma0), .RA(ra0)
  );

  amstrad_crtc #(.HS_DEFAULT(1'b1)) dut_hs1 (
    .CLK(CLK), .RESET(RESET), .CE(CE), .CS(CS), .RS(RS), .WE(WE), .RD(RD), .DI(DI),
    .DO(do1), .HSYNC(hs1), .VSYNC(vs1), .DE(de1), .MA(ma1), .RA(ra1)
  );

  always #5 CLK = ~CLK;

  int         total = 0;
  int         bad = 0;
  int         pos = 0;
  bit         chk_on = 1'b0;
  logic [7:0] mr [16];

  localparam int LogN = 20800;
  logic [13:0] ma_log  [LogN];
  logic [4:0]  ra_log  [LogN];
  logic        de_log  [LogN];
  logic        hs0_log [LogN];
  logic        hs1_log [LogN];
  logic        vs_log  [LogN];

  function automatic logic [7:0] mask_of(input int a);
    case (a)
      4, 6, 7, 10: mask_of = 8'h7f;
      5, 9, 11:    mask_of = 8'h1f;
      8:           mask_of = 8'h03;
      12, 14:      mask_of = 8'h3f;
      default:     mask_of = 8'hff;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s pos=%0d got=%0h expected=%0h", name, pos, got, exp);
    end
  endtask

  // Expected outputs from the position within the frame
  task automatic model_compare();
    int l, r, rows, nl, f, q, line, h, row, ra, base, ma, w0, w1, v0;
    bit adj, de, hse0, hse1, vse;
    l    = int'(mr[0]) + 1;
    r    = int'(mr[9]) + 1;
    rows = int'(mr[4]) + 1;
    nl   = rows * r + int'(mr[5]);
    f    = pos / (l * nl);
    q    = pos % (l * nl);
    line = q / l;
    h    = q % l;
    adj  = (line >= rows * r);
    row  = adj ? rows : line / r;
    ra   = adj ? r + line - rows * r : line % r;
    base = (f == 0) ? 0 : int'(mr[12] & 8'h3f) * 256 + int'(mr[13]);
    ma   = (base + row * int'(mr[1]) + h) % 16384;
    de   = !adj && h < int'(mr[1]) && row < int'(mr[6]);
    w0   = int'(mr[3][3:0]);
    w1   = (w0 == 0) ? 16 : w0;
    hse0 = w0 != 0 && h >= int'(mr[2]) && h < int'(mr[2]) + w0;
    hse1 = h >= int'(mr[2]) && h < int'(mr[2]) + w1;
    v0   = int'(mr[7]) * r;
    vse  = line >= v0 && line < v0 + 16;
    check("de",  32'(de0), 32'(de));
    check("ma",  32'(ma0), 32'(ma));
    check("ra",  32'(ra0), 32'(ra));
    check("hs",  32'(hs0), 32'(hse0));
    check("vs",  32'(vs0), 32'(vse));
    check("de1", 32'(de1), 32'(de));
    check("ma1", 32'(ma1), 32'(ma));
    check("ra1", 32'(ra1), 32'(ra));
    check("hs1", 32'(hs1), 32'(hse1));
    check("vs1", 32'(vs1), 32'(vse));
  endtask

  // One clock: track position, compare #1 after the edge, return on the falling edge
  task automatic tick();
    bit stepped;
    @(posedge CLK);
    stepped = 1'b0;
    if (RESET) pos = 0;
    else if (CE) begin
      pos++;
      stepped = 1'b1;
    end
    #1;
    if (chk_on && pos > 0) begin
      model_compare();
      if (stepped && pos < LogN) begin
        ma_log[pos]  = ma0;
        ra_log[pos]  = ra0;
        de_log[pos]  = de0;
        hs0_log[pos] = hs0;
        hs1_log[pos] = hs1;
        vs_log[pos]  = vs0;
      end
    end
    @(negedge CLK);
  endtask

  task automatic run_ces(input int n);
    for (int i = 0; i < n; i++) begin
      CE = 1'b1;
      tick();
      CE = 1'b0;
      if (i % 3 == 2) tick();
    end
  endtask

  task automatic wr(input int a, input int d);
    CS = 1'b1; RS = 1'b0; WE = 1'b1; DI = 8'(a);
    tick();
    RS = 1'b1; DI = 8'(d);
    tick();
    CS = 1'b0; WE = 1'b0; RS = 1'b0; DI = 8'h00;
    if (a < 16) mr[a] = 8'(d) & mask_of(a);
  endtask

  task automatic rd_reg(input int a, input int exp);
    CS = 1'b1; RS = 1'b0; WE = 1'b1; DI = 8'(a);
    tick();
    WE = 1'b0; RS = 1'b1; RD = 1'b1;
    #1;
    check("rd_reg",  32'(do0), 32'(exp));
    check("rd_reg1", 32'(do1), 32'(exp));
    CS = 1'b0; RD = 1'b0; RS = 1'b0;
  endtask

  task automatic rd_status(input int exp);
    CS = 1'b1; RS = 1'b0; RD = 1'b1;
    #1;
    check("status", 32'(do0), 32'(exp));
    CS = 1'b0; RD = 1'b0;
  endtask

  // Extra high bits on some values exercise the write masks
  task automatic configure(input int r3v, input int r5v);
    wr(0, 63);   wr(1, 40);   wr(2, 46);   wr(3, r3v);
    wr(4, 8'ha6); wr(5, r5v); wr(6, 25);   wr(7, 8'h9e);
    wr(9, 8'he7); wr(12, 8'hf0); wr(13, 0);
  endtask

  task automatic outputs_zero(input string name);
    check({name, "_hs"}, 32'(hs0), 0);
    check({name, "_vs"}, 32'(vs0), 0);
    check({name, "_de"}, 32'(de0), 0);
    check({name, "_ma"}, 32'(ma0), 0);
    check({name, "_ra"}, 32'(ra0), 0);
  endtask

  initial begin
    int cnt, first;
    RESET = 1'b1; CE = 1'b0; CS = 1'b0; RS = 1'b0; WE = 1'b0; RD = 1'b0; DI = 8'h00;
    for (int i = 0; i < 16; i++) mr[i] = 8'h00;
    tick();
    tick();
    outputs_zero("reset");
    RESET = 1'b0;
    tick();
    rd_status(8'h20);

    // Phase A: 312-line frame, 14-CE HSYNC
    configure(8'h8e, 0);
    rd_status(8'h00);
    wr(14, 8'hea);
    rd_reg(14, 8'h2a);
    rd_reg(12, 8'h00);
    wr(30, 8'h11);
    rd_reg(14, 8'h2a);
    wr(15, 8'h5c);
    rd_reg(15, 8'h5c);
    rd_reg(20, 8'h00);
    chk_on = 1'b1;
    run_ces(15500);
    rd_status(8'h20);
    wr(3, 8'h2e);
    run_ces(5000);

    cnt = 0; first = -1;
    for (int p = 1; p <= 19968; p++) begin
      if (vs_log[p] === 1'b1) begin
        cnt++;
        if (first < 0) first = p;
      end
    end
    check("vs_start", 32'(first), 15360);
    check("vs_len", 32'(cnt), 1024);
    cnt = 0;
    for (int p = 1; p <= 19968; p++) if (de_log[p] === 1'b1) cnt++;
    check("de_count", 32'(cnt), 8000);
    cnt = 0; first = -1;
    for (int p = 64; p < 128; p++) begin
      if (hs0_log[p] === 1'b1) begin
        cnt++;
        if (first < 0) first = p;
      end
    end
    check("hs_len", 32'(cnt), 14);
    check("hs_start", 32'(first), 110);
    cnt = 0;
    for (int p = 64; p < 128; p++) if (hs1_log[p] === 1'b1) cnt++;
    check("hs1_len", 32'(cnt), 14);
    check("ma_row1_f0", 32'(ma_log[512]), 32'h0028);
    check("ra_last", 32'(ra_log[19967]), 7);
    check("ma_frame", 32'(ma_log[19968]), 32'h3000);
    check("ra_frame", 32'(ra_log[19968]), 0);
    check("ra_row0_end", 32'(ra_log[448]), 7);
    check("ma_row1", 32'(ma_log[19968 + 512]), 32'h3028);

    // Asynchronous reset in the middle of a line
    chk_on = 1'b0;
    RESET = 1'b1;
    #1;
    outputs_zero("midreset");
    for (int i = 0; i < 16; i++) mr[i] = 8'h00;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    rd_status(8'h20);
    rd_reg(14, 8'h00);

    // Phase B: two adjust lines, R3 width 0
    configure(8'h80, 2);
    chk_on = 1'b1;
    run_ces(20200);

    check("ma_restart", 32'(ma_log[1]), 1);
    check("ra_adj0", 32'(ra_log[19968]), 8);
    check("de_adj0", 32'(de_log[19968]), 0);
    check("ra_adj1", 32'(ra_log[20032]), 9);
    check("ra_adj_end", 32'(ra_log[20095]), 9);
    check("ma_frame_b", 32'(ma_log[20096]), 32'h3000);
    check("ra_frame_b", 32'(ra_log[20096]), 0);
    cnt = 0;
    for (int p = 1; p <= 20096; p++) if (hs0_log[p] === 1'b1) cnt++;
    check("hs_none", 32'(cnt), 0);
    cnt = 0;
    for (int p = 64; p < 128; p++) if (hs1_log[p] === 1'b1) cnt++;
    check("hs1_default", 32'(cnt), 16);
    cnt = 0;
    for (int p = 1; p <= 20096; p++) if (de_log[p] === 1'b1) cnt++;
    check("de_count_b", 32'(cnt), 8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
